// File: rtl/post_box_sequencer.sv
// POST mailbox sequencer: decodes pulse groups on testreq into byte receive/transmit
// States: IDLE=count pulses, decide rx/tx ack | RX_BITS=shift in target byte | TX_BITS=shift out host byte
module post_box_sequencer #(
  parameter int unsigned BREAK_CYCLES = 480
) (
  input  logic       fpga_clock_48mhz,
  input  logic       reset_n,
  input  logic       testreq_3v,
  output logic       testack_noe,
  output logic [7:0] rx_data,
  output logic       rx_full,
  input  logic       rx_take,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_full
);

  localparam int unsigned BW = $clog2(BREAK_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RX_BITS = 2'd1, TX_BITS = 2'd2} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_sync;
  logic          r_req_q, r_framed, r_rx_ok, r_ack_n, r_rx_full, r_tx_full;
  logic [BW-1:0] r_brk_cnt;
  logic [4:0]    r_pcnt, w_pcnt_inc;
  logic [2:0]    r_bit_idx, w_bit_idx_nxt;
  logic [7:0]    r_rx_shift, w_rx_shift_nxt, r_rx_data;
  logic [7:0]    r_tx_byte, r_tx_shift, w_tx_shift_nxt;
  logic [3:0]    r_tx_pos, w_tx_pos_nxt;
  logic          w_req, w_rise, w_fall, w_break, w_ack, w_rx_ok_nxt, w_dequeue, w_rx_write;

  assign w_req      = r_sync[1];
  assign w_rise     = w_req & ~r_req_q;
  assign w_fall     = ~w_req & r_req_q;
  assign w_break    = ~w_req && (r_brk_cnt == BW'(BREAK_CYCLES - 1));
  assign w_pcnt_inc = (r_pcnt == 5'd31) ? r_pcnt : r_pcnt + 5'd1;

  assign testack_noe = r_ack_n;
  assign rx_data     = r_rx_data;
  assign rx_full     = r_rx_full;
  assign tx_full     = r_tx_full;

  // Break counter measures the current low stretch; it parks at BREAK_CYCLES so a break fires once
  always_ff @(posedge fpga_clock_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= 2'b00;
      r_req_q   <= 1'b0;
      r_brk_cnt <= '0;
    end else begin
      r_sync  <= {r_sync[0], testreq_3v};
      r_req_q <= w_req;
      if (w_req)
        r_brk_cnt <= '0;
      else if (r_brk_cnt != BW'(BREAK_CYCLES))
        r_brk_cnt <= r_brk_cnt + 1'b1;
    end
  end

  always_ff @(posedge fpga_clock_48mhz or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ack          = 1'b0;
    w_rx_ok_nxt    = r_rx_ok;
    w_bit_idx_nxt  = r_bit_idx;
    w_rx_shift_nxt = r_rx_shift;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_pos_nxt   = r_tx_pos;
    w_dequeue      = 1'b0;
    w_rx_write     = 1'b0;

    if (w_rise && r_framed) begin
      case (r_state)
        IDLE: begin
          if (w_pcnt_inc == 5'd3) begin
            w_ack       = ~r_rx_full;
            w_rx_ok_nxt = ~r_rx_full;
          end else if (w_pcnt_inc == 5'd4 && r_tx_full) begin
            w_ack        = 1'b1;
            w_dequeue    = 1'b1;
            w_tx_pos_nxt = 4'd0;
            w_state_nxt  = TX_BITS;
          end
        end
        RX_BITS: begin
          if (w_pcnt_inc == 5'd3) begin
            w_ack       = ~r_rx_full;
            w_rx_ok_nxt = ~r_rx_full;
            w_state_nxt = IDLE;
          end
        end
        TX_BITS: begin
          // Position since the last dequeue keeps data flowing after pcnt saturates
          w_tx_pos_nxt = (r_tx_pos == 4'd15) ? r_tx_pos : r_tx_pos + 4'd1;
          if (w_tx_pos_nxt <= 4'd8) begin
            w_ack          = r_tx_shift[7];
            w_tx_shift_nxt = {r_tx_shift[6:0], 1'b0};
          end else if (w_tx_pos_nxt == 4'd13 && r_pcnt != 5'd31 && r_tx_full) begin
            w_ack        = 1'b1;
            w_dequeue    = 1'b1;
            w_tx_pos_nxt = 4'd0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    if (w_break) begin
      w_rx_ok_nxt = 1'b0;
      case (r_state)
        IDLE: begin
          if (r_pcnt == 5'd3 && r_rx_ok) begin
            w_state_nxt    = RX_BITS;
            w_bit_idx_nxt  = 3'd7;
            w_rx_shift_nxt = 8'h00;
          end
        end
        RX_BITS: begin
          if (r_pcnt == 5'd1 || r_pcnt == 5'd2) begin
            w_rx_shift_nxt = {r_rx_shift[6:0], (r_pcnt == 5'd1)};
            w_bit_idx_nxt  = r_bit_idx - 3'd1;
            if (r_bit_idx == 3'd0) begin
              w_rx_write  = 1'b1;
              w_state_nxt = IDLE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    if (w_dequeue) w_tx_shift_nxt = r_tx_byte;
  end

  always_ff @(posedge fpga_clock_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_pcnt     <= 5'd0;
      r_framed   <= 1'b0;
      r_rx_ok    <= 1'b0;
      r_ack_n    <= 1'b1;
      r_bit_idx  <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_full  <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_tx_shift <= 8'h00;
      r_tx_full  <= 1'b0;
      r_tx_pos   <= 4'd0;
    end else begin
      r_rx_ok    <= w_rx_ok_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_pos   <= w_tx_pos_nxt;

      // Pulses before the first break belong to a train already in flight
      if (w_break) begin
        r_pcnt   <= 5'd0;
        r_framed <= 1'b1;
      end else if (w_rise && r_framed) begin
        r_pcnt <= w_pcnt_inc;
      end

      if (w_rise)      r_ack_n <= ~w_ack;
      else if (w_fall) r_ack_n <= 1'b1;

      if (w_rx_write) begin
        r_rx_data <= w_rx_shift_nxt;
        r_rx_full <= 1'b1;
      end else if (rx_take) begin
        r_rx_full <= 1'b0;
      end

      if (w_dequeue) begin
        r_tx_full <= tx_load;
        if (tx_load) r_tx_byte <= tx_data;
      end else if (tx_load && !r_tx_full) begin
        r_tx_full <= 1'b1;
        r_tx_byte <= tx_data;
      end
    end
  end

endmodule
